segasys1_sound_cmd_rx: RTL and testbench
========================================

# segasys1_sound_cmd_rx

Sound-side receiver for the main CPU's sound-command interface: captures each `SNDRQ`/`SNDNO` request into a command queue, raises an NMI request to the sound CPU, presents the queued command on the sound CPU read bus, and retires it when the read completes. Sits between the main CPU block and the sound CPU block in the top level, all in the 48 MHz domain.

## Interface
- `DEPTH_LOG2`, 2: queue depth is 2^DEPTH_LOG2 entries. Applies only with the FIFO build; see Configuration.
- `NMI_GAP`, 48: minimum number of CLK48M cycles `SNMI` stays low between two NMI pulses. Range 1–255.
- `CLK48M` in 1: the only clock. All logic updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `SNDRQ` in 1: sound request from the main CPU, synchronous to CLK48M. High for ≥1 cycle per command.
- `SNDNO` in 8: command byte. Valid on the `SNDRQ` rising edge.
- `SCPU_CS` in 1: sound CPU selects the command latch (read at $E000).
- `SCPU_RD` in 1: sound CPU read strobe. Level, high for the whole read.
- `SDO` out 8: command byte presented to the sound CPU data selector.
- `SNMI` out 1: NMI request to the sound CPU, active-high.
- `OVF` out 1: sticky overflow flag.

## Operation
- Push event: `SNDRQ` high this cycle while its registered copy is low. One push per rising edge, regardless of how long `SNDRQ` stays high.
- Read event:
  - `rd_act = SCPU_CS & SCPU_RD`.
  - A pop happens on the falling edge of `rd_act`, when the registered copy is 1 and the current value is 0.
  - `SDO` does not change while `rd_act` is high.
- `SDO` shows the queue head when the queue is non-empty, otherwise the last popped byte. After reset it is 8'h00.
- Reading an empty queue returns the last popped byte and changes no state.
- Full queue with a push and no pop in the same cycle: the new byte is dropped and `OVF` is set. `OVF` clears only on `RESET`.
- Push and pop in the same cycle: both happen and count is unchanged. On a full queue this is legal and does not set `OVF`. On an empty queue the pop is ignored and the push happens.
- Read and write pointers wrap modulo the depth. Count is DEPTH_LOG2+1 bits wide.
- NMI state machine:
  - IDLE → PEND when the queue is non-empty. `SNMI` goes to 1 on the next cycle.
  - PEND → SERV on a pop. `SNMI` goes to 0 and the gap counter loads `NMI_GAP`-1.
  - SERV: the gap counter decrements each cycle. At 0 go to IDLE, which re-enters PEND at once if the queue is still non-empty.
  - A pop while in IDLE or SERV dequeues the entry with no state change.

## Timing
- Reset values: `SNMI`=0, `OVF`=0, `SDO`=8'h00, queue empty, state IDLE, gap counter 0.
- Push latency:
  - `SNDRQ` rising at cycle n writes the queue at the end of cycle n.
  - `SDO` shows the head at n+1.
  - IDLE→PEND at the end of n+1.
  - `SNMI` is high at n+2.
- Pop latency:
  - `rd_act` falls at cycle m, so the pop is registered at the end of m.
  - `SNMI` is low and `SDO` shows the next head at m+1.
- Minimum `SNMI` low time between pulses: `NMI_GAP`+1 cycles.
- `RESET` mid-operation: on the next edge everything returns to its reset value and queued commands are discarded. A `SNDRQ` that is high during `RESET` does not push after release until it falls and rises again.

## Configuration
- `SEGASYS1_SNDCMD_FIFO_EN` defined: the 2^DEPTH_LOG2-entry queue described above, with `OVF` behaving as specified.
- Not defined:
  - Single 8-bit latch, overwritten by every push.
  - "Non-empty" becomes a pending flag, set by a push and cleared by a pop.
  - `OVF` is set by a push while the flag is already set.
  - `DEPTH_LOG2` is ignored.

## Structure
- Shared package `segasys1_pkg`:
  - NMI state enum (IDLE, PEND, SERV).
  - Command width constant (8).
  - Default `NMI_GAP` constant.
- One sub-module, `segasys1_cmd_fifo`: synchronous FIFO with push, pop, head, empty, full and count.
  - In the build without the macro it is replaced by the inline latch.

## Test plan
- Reset, then a single push: `SNDNO`=8'h81 with one `SNDRQ` pulse → `SNMI`=1 two cycles later and `SDO`=8'h81. A 4-cycle read → `SNMI`=0 the cycle after `rd_act` falls.
- Burst of pushes: 8'h10, 8'h11, 8'h12 on consecutive edges → three reads return 10, 11, 12 in order. `SNMI` pulses three times, each gap ≥`NMI_GAP`+1 cycles.
- Overflow (FIFO build, DEPTH_LOG2=2): five pushes with no reads → `OVF`=1 and the reads return only the first four bytes. Same-cycle push and pop on a full queue → `OVF` stays 0.
- Held request: `SNDRQ` high for 20 cycles → exactly one entry queued.
- Reset mid-operation: `RESET` while in PEND with 2 entries queued → next cycle `SNMI`=0, queue empty, `SDO`=8'h00, `OVF`=0.
- Latch build (macro undefined): push 8'h20, then 8'h21 before any read → `SDO`=8'h21, `OVF`=1, and a single NMI is serviced.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared definitions for the System 1 sound-command path: command width,
// default NMI spacing and the NMI handshake state encoding.
package segasys1_pkg;

  localparam int CMD_W       = 8;
  localparam int NMI_GAP_DEF = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/segasys1_cmd_fifo.sv
// Small synchronous command FIFO. A pop on an empty queue is ignored, and a
// push on a full queue lands only if a pop frees a slot in the same cycle.
module segasys1_cmd_fifo
  import segasys1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [CMD_W-1:0]      din,
  output logic [CMD_W-1:0]      head,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [CMD_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at the depth naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push & ~do_pop)      count <= count + CNT_ONE;
      else if (do_pop & ~do_push) count <= count - CNT_ONE;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/segasys1_sound_cmd_rx.sv
// Sound-side receiver for main-CPU sound commands. Captures each SNDRQ rising
// edge, raises SNMI to the sound CPU, presents the command on SDO and retires
// it when the sound CPU read completes.
// Build option: SEGASYS1_SNDCMD_FIFO_EN selects a 2^DEPTH_LOG2-entry queue;
// without it a single overwrite-on-push latch with a pending flag is used.
module segasys1_sound_cmd_rx
  import segasys1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_GAP    = NMI_GAP_DEF
) (
  input  logic             CLK48M,
  input  logic             RESET,
  input  logic             SNDRQ,
  input  logic [CMD_W-1:0] SNDNO,
  input  logic             SCPU_CS,
  input  logic             SCPU_RD,
  output logic [CMD_W-1:0] SDO,
  output logic             SNMI,
  output logic             OVF
);

  localparam logic [7:0] GAP_LOAD = 8'(NMI_GAP - 1);

  logic                  sndrq_q, rd_act, rd_act_q;
  logic                  push, pop;
  logic                  non_empty, ovf_set;
  logic [CMD_W-1:0]      sdo_live, sdo_hold;
  logic [DEPTH_LOG2:0]   q_count;
  nmi_state_e            state;
  logic [7:0]            gap_cnt;

  assign rd_act = SCPU_CS & SCPU_RD;
  assign push   = SNDRQ & ~sndrq_q;
  assign pop    = rd_act_q & ~rd_act;

  // SNDRQ copy tracks the pin even in reset, so a request held across reset
  // release is not mistaken for a new rising edge.
  always_ff @(posedge CLK48M) begin
    sndrq_q <= SNDRQ;
  end

  // Read-strobe copy for falling-edge (read complete) detection.
  always_ff @(posedge CLK48M) begin
    if (RESET) rd_act_q <= 1'b0;
    else       rd_act_q <= rd_act;
  end

`ifdef SEGASYS1_SNDCMD_FIFO_EN
  logic [CMD_W-1:0] q_head, last_pop;
  logic             q_empty, q_full;

  segasys1_cmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK48M),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (SNDNO),
    .head  (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  // A full queue only overflows when no read retires an entry this cycle.
  assign ovf_set  = push & q_full & ~pop;
  assign sdo_live = q_empty ? last_pop : q_head;

  // Remember the last retired byte so empty-queue reads return it.
  always_ff @(posedge CLK48M) begin
    if (RESET)              last_pop <= '0;
    else if (pop & ~q_empty) last_pop <= q_head;
  end
`else
  logic [CMD_W-1:0] latch_q;
  logic             pend;

  // Single latch: every push overwrites; the pending flag marks an unread byte.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      latch_q <= '0;
      pend    <= 1'b0;
    end else begin
      if (push) begin
        latch_q <= SNDNO;
        pend    <= 1'b1;
      end else if (pop) begin
        pend    <= 1'b0;
      end
    end
  end

  assign q_count  = (DEPTH_LOG2+1)'(pend);
  assign ovf_set  = push & pend;
  // The latch keeps its byte after a pop, so it doubles as the last-read value.
  assign sdo_live = latch_q;
`endif

  assign non_empty = (q_count != '0);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge CLK48M) begin
    if (RESET)        OVF <= 1'b0;
    else if (ovf_set) OVF <= 1'b1;
  end

  // Freeze the presented byte for the duration of a sound CPU read.
  always_ff @(posedge CLK48M) begin
    if (RESET)        sdo_hold <= '0;
    else if (~rd_act) sdo_hold <= sdo_live;
  end

  assign SDO = rd_act ? sdo_hold : sdo_live;

  // NMI handshake: raise on pending work, drop on read completion, then hold
  // low for the gap before another request may be raised.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      state   <= IDLE;
      gap_cnt <= '0;
      SNMI    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (non_empty) begin
          state <= PEND;
          SNMI  <= 1'b1;
        end
        PEND: if (pop) begin
          state   <= SERV;
          SNMI    <= 1'b0;
          gap_cnt <= GAP_LOAD;
        end
        SERV: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          state <= IDLE;
          SNMI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segasys1_sound_cmd_rx.sv
// Self-checking bench for segasys1_sound_cmd_rx. A byte scoreboard is updated
// as commands are pushed and popped; reads compare SDO against its head.
module tb_segasys1_sound_cmd_rx;

  localparam int GAP = 8;
  localparam int DL2 = 2;
`ifdef SEGASYS1_SNDCMD_FIFO_EN
  localparam bit FIFO  = 1'b1;
  localparam int DEPTH = 1 << DL2;
`else
  localparam bit FIFO  = 1'b0;
  localparam int DEPTH = 1;
`endif

  logic       CLK48M = 1'b0;
  logic       RESET  = 1'b1;
  logic       SNDRQ  = 1'b0;
  logic [7:0] SNDNO  = 8'h00;
  logic       SCPU_CS = 1'b0;
  logic       SCPU_RD = 1'b0;
  logic [7:0] SDO;
  logic       SNMI;
  logic       OVF;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_pop = 8'h00;
  logic       exp_ovf  = 1'b0;

  segasys1_sound_cmd_rx #(
    .DEPTH_LOG2 (DL2),
    .NMI_GAP    (GAP)
  ) dut (
    .CLK48M  (CLK48M),
    .RESET   (RESET),
    .SNDRQ   (SNDRQ),
    .SNDNO   (SNDNO),
    .SCPU_CS (SCPU_CS),
    .SCPU_RD (SCPU_RD),
    .SDO     (SDO),
    .SNMI    (SNMI),
    .OVF     (OVF)
  );

  always #5 CLK48M = ~CLK48M;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (FIFO) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else                       exp_q.push_back(b);
    end else begin
      if (exp_q.size() != 0) begin
        exp_ovf  = 1'b1;
        exp_q[0] = b;
      end else begin
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic model_pop();
    if (exp_q.size() != 0) last_pop = exp_q.pop_front();
  endtask

  task automatic model_clear();
    exp_q.delete();
    last_pop = 8'h00;
    exp_ovf  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    SNDNO = b;
    SNDRQ = 1'b1;
    model_push(b);
    tick();
    SNDRQ = 1'b0;
    tick();
  endtask

  // Read lasting len cycles; SDO must match the scoreboard head throughout.
  task automatic read_cmd(input int len, input string nm);
    logic [7:0] want;
    want = (exp_q.size() != 0) ? exp_q[0] : last_pop;
    SCPU_CS = 1'b1;
    SCPU_RD = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK48M);
      checks++;
      if (SDO !== want) begin
        errors++;
        $display("FAIL %s_sdo: got %h want %h", nm, SDO, want);
      end
      tick();
    end
    SCPU_CS = 1'b0;
    SCPU_RD = 1'b0;
    model_pop();
    tick();
    #1;
    checks++;
    if (SNMI !== 1'b0) begin
      errors++;
      $display("FAIL %s_nmi_clear: got %b want 0", nm, SNMI);
    end
  endtask

  // Wait (bounded) for SNMI high; low returns the low cycles seen first.
  task automatic wait_nmi(input int bound, input string nm, output int low);
    low = 0;
    @(negedge CLK48M);
    while (SNMI !== 1'b1 && low < bound) begin
      low++;
      @(negedge CLK48M);
    end
    checks++;
    if (SNMI !== 1'b1) begin
      errors++;
      $display("FAIL %s_nmi_timeout: got %b want 1 within %0d cycles", nm, SNMI, bound);
    end
    tick();
  endtask

  task automatic wait_quiet(input int n, input string nm);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK48M);
      if (SNMI !== 1'b0) hi++;
    end
    tick();
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL %s_quiet: SNMI high %0d cycles want 0", nm, hi);
    end
  endtask

  task automatic check_ovf(input string nm);
    @(negedge CLK48M);
    checks++;
    if (OVF !== exp_ovf) begin
      errors++;
      $display("FAIL %s_ovf: got %b want %b", nm, OVF, exp_ovf);
    end
    tick();
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    SNDRQ   = 1'b0;
    SCPU_CS = 1'b0;
    SCPU_RD = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    model_clear();
    @(negedge CLK48M);
    checks += 3;
    if (SNMI !== 1'b0) begin errors++; $display("FAIL reset_snmi: got %b want 0", SNMI); end
    if (OVF  !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    if (SDO  !== 8'h00) begin errors++; $display("FAIL reset_sdo: got %h want 00", SDO); end
    tick();
  endtask

  task automatic test_single();
    SNDNO = 8'h81;
    SNDRQ = 1'b1;
    model_push(8'h81);
    tick();
    SNDRQ = 1'b0;
    @(negedge CLK48M);
    checks += 2;
    if (SDO !== 8'h81) begin errors++; $display("FAIL single_sdo_n1: got %h want 81", SDO); end
    if (SNMI !== 1'b0) begin errors++; $display("FAIL single_snmi_n1: got %b want 0", SNMI); end
    tick();
    @(negedge CLK48M);
    checks++;
    if (SNMI !== 1'b1) begin errors++; $display("FAIL single_snmi_n2: got %b want 1", SNMI); end
    tick();
    read_cmd(4, "single");
    checks++;
    if (SDO !== 8'h81) begin errors++; $display("FAIL single_sdo_after: got %h want 81", SDO); end
    wait_quiet(GAP + 4, "single");
    check_ovf("single");
  endtask

  task automatic test_burst();
    int low;
    int npulse;
    push_byte(8'h10);
    push_byte(8'h11);
    push_byte(8'h12);
    npulse = FIFO ? 3 : 1;
    for (int i = 0; i < npulse; i++) begin
      wait_nmi(4 * GAP + 20, "burst", low);
      if (i > 0) begin
        checks++;
        if (low != GAP + 1) begin
          errors++;
          $display("FAIL burst_gap: got %0d low cycles want %0d", low, GAP + 1);
        end
      end
      read_cmd(2, "burst");
    end
    wait_quiet(GAP + 4, "burst");
    check_ovf("burst");
  endtask

  task automatic test_held();
    int low;
    SNDNO = 8'h5A;
    SNDRQ = 1'b1;
    model_push(8'h5A);
    tick();
    SNDNO = 8'h77;
    repeat (19) tick();
    SNDRQ = 1'b0;
    tick();
    wait_nmi(4 * GAP + 20, "held", low);
    read_cmd(3, "held");
    wait_quiet(GAP + 4, "held");
    read_cmd(2, "held_empty");
    wait_quiet(GAP + 4, "held_empty");
    check_ovf("held");
  endtask

`ifdef SEGASYS1_SNDCMD_FIFO_EN
  task automatic test_overflow();
    int low;
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    check_ovf("ovf_set");
    for (int i = 0; i < 4; i++) begin
      wait_nmi(4 * GAP + 20, "ovf_drain", low);
      read_cmd(2, "ovf_drain");
    end
    wait_quiet(GAP + 4, "ovf_drain");
    read_cmd(2, "ovf_empty");
    wait_quiet(GAP + 4, "ovf_empty");
    test_reset();
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
    check_ovf("full_no_ovf");
    wait_nmi(4 * GAP + 20, "same", low);
    SCPU_CS = 1'b1;
    SCPU_RD = 1'b1;
    tick();
    tick();
    SCPU_CS = 1'b0;
    SCPU_RD = 1'b0;
    SNDNO = 8'hC5;
    SNDRQ = 1'b1;
    model_pop();
    model_push(8'hC5);
    tick();
    SNDRQ = 1'b0;
    @(negedge CLK48M);
    checks += 2;
    if (OVF !== exp_ovf) begin errors++; $display("FAIL same_ovf: got %b want %b", OVF, exp_ovf); end
    if (SNMI !== 1'b0) begin errors++; $display("FAIL same_snmi: got %b want 0", SNMI); end
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_nmi(4 * GAP + 20, "same_drain", low);
      read_cmd(2, "same_drain");
    end
    wait_quiet(GAP + 4, "same_drain");
    check_ovf("same_end");
  endtask
`else
  task automatic test_latch();
    int low;
    test_reset();
    push_byte(8'h20);
    push_byte(8'h21);
    @(negedge CLK48M);
    checks += 2;
    if (SDO !== exp_q[0]) begin errors++; $display("FAIL latch_sdo: got %h want %h", SDO, exp_q[0]); end
    if (OVF !== exp_ovf) begin errors++; $display("FAIL latch_ovf: got %b want %b", OVF, exp_ovf); end
    tick();
    wait_nmi(4 * GAP + 20, "latch", low);
    read_cmd(3, "latch");
    wait_quiet(GAP + 4, "latch");
  endtask
`endif

  task automatic test_reset_mid();
    int low;
    push_byte(8'h31);
    push_byte(8'h32);
    wait_nmi(4 * GAP + 20, "rstmid", low);
    RESET = 1'b1;
    SNDNO = 8'h99;
    SNDRQ = 1'b1;
    tick();
    RESET = 1'b0;
    model_clear();
    @(negedge CLK48M);
    checks += 3;
    if (SNMI !== 1'b0) begin errors++; $display("FAIL rstmid_snmi: got %b want 0", SNMI); end
    if (SDO !== 8'h00) begin errors++; $display("FAIL rstmid_sdo: got %h want 00", SDO); end
    if (OVF !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", OVF); end
    tick();
    repeat (3) tick();
    SNDRQ = 1'b0;
    wait_quiet(GAP + 4, "rstmid");
    @(negedge CLK48M);
    checks++;
    if (SDO !== 8'h00) begin errors++; $display("FAIL rstmid_sdo_late: got %h want 00", SDO); end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_burst();
    test_held();
`ifdef SEGASYS1_SNDCMD_FIFO_EN
    test_overflow();
`else
    test_latch();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
